uart_alu_frame_ctrl: RTL

- Byte-level framer between uart_rx/uart_tx and the alu; replaces the word_rx/word_tx pair plus ad-hoc operand capture.
- Collects a frame of three WORD_W words (operand A, operand B, op), drives the alu, waits ALU_LAT cycles, and returns the result as bytes over the uart_tx handshake.
- Adds parametrised width and byte order, optional hi-word return, inter-byte timeout and overrun reporting.

---
 rtl/uart_calc_pkg.sv | 16 +
 rtl/rise_detect.sv | 25 ++
 rtl/uart_alu_frame_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_calc_pkg.sv
// Shared types for the UART/ALU frame controller: FSM state encoding and ALU op width.
package uart_calc_pkg;

    typedef enum logic [2:0] {
        RX_A,
        RX_B,
        RX_OP,
        EXEC,
        TX_LOAD,
        TX_WAIT,
        TX_GAP
    } state_e;

    localparam int ALU_OP_W = 4;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector; a level already high when reset releases is not an edge.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic level_i,
    output logic pulse_o
);

    logic prev_q;
    logic pulse_q;

    // prev_q resets to 1 so a level held high through reset cannot fake an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= level_i;
            pulse_q <= level_i & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/uart_alu_frame_ctrl.sv
// Byte framer between the UART pair and the ALU: gathers A, B and op words, runs the ALU,
// then streams the result back one byte per uart_tx handshake.
module uart_alu_frame_ctrl
    import uart_calc_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int MSB_FIRST = 1,
    parameter int SEND_HI   = 0,
    parameter int ALU_LAT   = 1,
    parameter int TIMEOUT   = 20000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_byte,
    input  logic                rx_done,
    output logic [WORD_W-1:0]   alu_a,
    output logic [WORD_W-1:0]   alu_b,
    output logic [ALU_OP_W-1:0] alu_op,
    input  logic [WORD_W-1:0]   alu_lo,
    input  logic [WORD_W-1:0]   alu_hi,
    output logic [7:0]          tx_byte,
    output logic                tx_send,
    input  logic                tx_done,
    output logic                busy,
    output logic                frame_err,
    output logic                rx_overrun
);

    localparam int BYTES     = WORD_W / 8;
    localparam int TOTAL     = (SEND_HI != 0) ? 2 * BYTES : BYTES;
    localparam int TO_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int RES_IDX_W = $clog2(2 * WORD_W);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic rxEdge;
    logic txEdge;

    rise_detect u_rx_rise (.clk(clk), .rst(rst), .level_i(rx_done), .pulse_o(rxEdge));
    rise_detect u_tx_rise (.clk(clk), .rst(rst), .level_i(tx_done), .pulse_o(txEdge));

    state_e                state_q, state_d;
    logic [WORD_W-1:0]     shift_q, shift_d;
    logic [WORD_W-1:0]     aluA_q, aluA_d;
    logic [WORD_W-1:0]     aluB_q, aluB_d;
    logic [ALU_OP_W-1:0]   aluOp_q, aluOp_d;
    logic [2*WORD_W-1:0]   res_q, res_d;
    logic [3:0]            byteCnt_q, byteCnt_d;
    logic [3:0]            latCnt_q, latCnt_d;
    logic [4:0]            txIdx_q, txIdx_d;
    logic [TO_W-1:0]       toCnt_q, toCnt_d;
    logic                  frameErr_q, frameErr_d;
    logic                  overrun_q, overrun_d;

    logic                  inRx;
    logic                  frameOpen;
    logic                  timedOut;
    logic [WORD_W-1:0]     newWord;

    assign inRx      = (state_q == RX_A) || (state_q == RX_B) || (state_q == RX_OP);
    assign frameOpen = (state_q != RX_A) || (byteCnt_q != '0);
    assign timedOut  = (TIMEOUT != 0) && inRx && frameOpen && (toCnt_q == TO_LAST);
    assign newWord   = (MSB_FIRST != 0)
                     ? ((shift_q << 8) | WORD_W'(rx_byte))
                     : ((shift_q >> 8) | (WORD_W'(rx_byte) << (WORD_W - 8)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q    <= '0;
            aluA_q     <= '0;
            aluB_q     <= '0;
            aluOp_q    <= '0;
            res_q      <= '0;
            byteCnt_q  <= '0;
            latCnt_q   <= '0;
            txIdx_q    <= '0;
            toCnt_q    <= '0;
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            aluA_q     <= aluA_d;
            aluB_q     <= aluB_d;
            aluOp_q    <= aluOp_d;
            res_q      <= res_d;
            byteCnt_q  <= byteCnt_d;
            latCnt_q   <= latCnt_d;
            txIdx_q    <= txIdx_d;
            toCnt_q    <= toCnt_d;
            frameErr_q <= frameErr_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        aluA_d     = aluA_q;
        aluB_d     = aluB_q;
        aluOp_d    = aluOp_q;
        res_d      = res_q;
        byteCnt_d  = byteCnt_q;
        latCnt_d   = latCnt_q;
        txIdx_d    = txIdx_q;
        toCnt_d    = toCnt_q;
        frameErr_d = 1'b0;
        overrun_d  = rxEdge && !inRx;

        case (state_q)
            RX_A, RX_B, RX_OP: begin
                // An arriving byte beats a timeout expiring in the same cycle
                if (rxEdge) begin
                    toCnt_d = '0;
                    if (byteCnt_q == 4'(BYTES - 1)) begin
                        byteCnt_d = '0;
                        shift_d   = '0;
                        if (state_q == RX_A) begin
                            aluA_d  = newWord;
                            state_d = RX_B;
                        end else if (state_q == RX_B) begin
                            aluB_d  = newWord;
                            state_d = RX_OP;
                        end else begin
                            aluOp_d  = newWord[ALU_OP_W-1:0];
                            latCnt_d = '0;
                            state_d  = EXEC;
                        end
                    end else begin
                        byteCnt_d = byteCnt_q + 4'd1;
                        shift_d   = newWord;
                    end
                end else if (timedOut) begin
                    frameErr_d = 1'b1;
                    shift_d    = '0;
                    byteCnt_d  = '0;
                    toCnt_d    = '0;
                    state_d    = RX_A;
                end else if (frameOpen && (TIMEOUT != 0)) begin
                    toCnt_d = toCnt_q + 1'b1;
                end
            end
            EXEC: begin
                if (latCnt_q == 4'(ALU_LAT - 1)) begin
                    res_d   = {alu_hi, alu_lo};
                    txIdx_d = '0;
                    state_d = TX_LOAD;
                end else begin
                    latCnt_d = latCnt_q + 4'd1;
                end
            end
            TX_LOAD: state_d = TX_WAIT;
            TX_WAIT: begin
                if (txEdge) begin
                    state_d = TX_GAP;
                end
            end
            TX_GAP: begin
                if (txIdx_q == 5'(TOTAL - 1)) begin
                    state_d = RX_A;
                end else begin
                    txIdx_d = txIdx_q + 5'd1;
                    state_d = TX_LOAD;
                end
            end
            default: state_d = RX_A;
        endcase
    end

    int                   slotIdx;
    int                   wordOff;
    int                   byteOff;
    logic [RES_IDX_W-1:0] bitOff;

    // Result stream order: lo word then hi word, bytes within a word per MSB_FIRST
    always_comb begin
        slotIdx = int'(txIdx_q);
        wordOff = 0;
        if (slotIdx >= BYTES) begin
            slotIdx = slotIdx - BYTES;
            wordOff = WORD_W;
        end
        byteOff    = (MSB_FIRST != 0) ? (BYTES - 1 - slotIdx) : slotIdx;
        bitOff     = RES_IDX_W'(wordOff + 8 * byteOff);
        tx_byte    = res_q[bitOff +: 8];
        tx_send    = (state_q == TX_LOAD) || (state_q == TX_WAIT);
        busy       = frameOpen;
        alu_a      = aluA_q;
        alu_b      = aluB_q;
        alu_op     = aluOp_q;
        frame_err  = frameErr_q;
        rx_overrun = overrun_q;
    end

endmodule
